efuse_array_model: RTL

// - Synthesizable responder for the eFuse macro pin interface (pgmen/rden/aen/addr -> rdata); stands in for the hard macro on FPGA and in block sims.
// - Sits on the macro side of the controller mux and consumes its registered pin outputs.
// - Holds a one-time-programmable bit array, checks pulse timing and protocol, and flags violations in a sticky status.

---
 rtl/efuse_array_model_if.sv | 25 ++
 rtl/efuse_array_model.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/efuse_array_model_if.sv
// eFuse macro pin bundle between the controller (master) and the macro (slave).
// Pins: efuse_pgmen_i, efuse_rden_i, efuse_aen_i, efuse_addr_i[7:0] -> efuse_rdata_o[7:0].
interface efuse_array_model_if;
   logic       efuse_pgmen_i;
   logic       efuse_rden_i;
   logic       efuse_aen_i;
   logic [7:0] efuse_addr_i;
   logic [7:0] efuse_rdata_o;

   modport master (
      output efuse_pgmen_i,
      output efuse_rden_i,
      output efuse_aen_i,
      output efuse_addr_i,
      input  efuse_rdata_o
   );

   modport slave (
      input  efuse_pgmen_i,
      input  efuse_rden_i,
      input  efuse_aen_i,
      input  efuse_addr_i,
      output efuse_rdata_o
   );
endinterface

// File: rtl/efuse_array_model.sv
// Synthesizable eFuse macro stand-in: OTP bit array, pulse timing and protocol checks.
// Ports: clk, rst_n (async low), pin (slave: pgmen/rden/aen/addr -> rdata),
//   err_clr_i, pgm_done_o (1-cycle), prot_err_o (sticky), err_code_o (first code).
// Option: EFUSE_MODEL_PRELOAD_EN resets the array to PRELOAD_VAL instead of zero.
module efuse_array_model #(
   parameter int                 NBYTE       = 32,
   parameter int                 T_PGM_MIN   = 4,
   parameter int                 T_PGM_MAX   = 16,
   parameter int                 RD_LAT      = 2,
   parameter logic [NBYTE*8-1:0] PRELOAD_VAL = '0
) (
   input  logic                clk,
   input  logic                rst_n,
   efuse_array_model_if.slave  pin,
   input  logic                err_clr_i,
   output logic                pgm_done_o,
   output logic                prot_err_o,
   output logic [2:0]          err_code_o
);

   localparam int AW      = NBYTE * 8;
   localparam int CNT_SAT = T_PGM_MAX + 1;
   localparam int CW      = $clog2(CNT_SAT + 1);

`ifdef EFUSE_MODEL_PRELOAD_EN
   localparam logic [AW-1:0] ARR_RST = PRELOAD_VAL;
`else
   // Image masked off: the array comes up blank.
   localparam logic [AW-1:0] ARR_RST = {AW{1'b0}} & PRELOAD_VAL;
`endif

   typedef enum logic [1:0] {
      S_IDLE,
      S_PGM,
      S_RD,
      S_ABORT
   } state_e;

   state_e          state_q, state_d;
   logic            aen_d1_q;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            pgmen_q, pgmen_d;
   logic            rden_q, rden_d;
   logic [7:0]      addr_q, addr_d;
   logic [AW-1:0]   arr_q, arr_d;
   logic [7:0]      rdata_q, rdata_d;
   logic            done_q, done_d;
   logic            err_q, err_d;
   logic [2:0]      ecode_q, ecode_d;

   logic            aen;
   logic            rise;
   logic            chg;
   logic            idx_bad;
   logic            op_end;
   logic            new_err;
   logic [2:0]      code_new;

   assign aen     = pin.efuse_aen_i;
   assign rise    = aen & ~aen_d1_q;
   assign idx_bad = int'(pin.efuse_addr_i[7:3]) >= NBYTE;
   // Any pin movement against the values latched at aen rise.
   assign chg     = (pin.efuse_addr_i  != addr_q)
                  | (pin.efuse_pgmen_i != pgmen_q)
                  | (pin.efuse_rden_i  != rden_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      pgmen_d  = pgmen_q;
      rden_d   = rden_q;
      addr_d   = addr_q;
      arr_d    = arr_q;
      rdata_d  = rdata_q;
      done_d   = 1'b0;
      code_new = 3'd0;
      op_end   = 1'b0;
      err_d    = err_q;
      ecode_d  = ecode_q;

      // Counter counts aen-high cycles, 1 on the rise edge, saturating.
      if (rise) begin
         cnt_d   = CW'(1);
         pgmen_d = pin.efuse_pgmen_i;
         rden_d  = pin.efuse_rden_i;
         addr_d  = pin.efuse_addr_i;
      end else if (aen && cnt_q != CW'(CNT_SAT)) begin
         cnt_d = cnt_q + CW'(1);
      end

      unique case (state_q)
         S_IDLE: begin
            if (rise) begin
               unique case ({pin.efuse_pgmen_i, pin.efuse_rden_i})
                  2'b11: begin
                     state_d  = S_ABORT;
                     code_new = 3'd1;
                  end
                  2'b00: begin
                     state_d  = S_ABORT;
                     code_new = 3'd2;
                  end
                  2'b10, 2'b01: begin
                     if (idx_bad) begin
                        state_d  = S_ABORT;
                        code_new = 3'd3;
                     end else if (pin.efuse_pgmen_i) begin
                        state_d = S_PGM;
                     end else begin
                        state_d = S_RD;
                     end
                  end
                  default: ;
               endcase
            end
         end
         S_PGM: begin
            if (aen) begin
               if (chg) begin
                  state_d  = S_ABORT;
                  code_new = 3'd7;
               end
            end else begin
               state_d = S_IDLE;
               op_end  = 1'b1;
               if (cnt_q < CW'(T_PGM_MIN)) begin
                  code_new = 3'd4;
               end else begin
                  arr_d[addr_q] = 1'b1;
                  done_d        = 1'b1;
                  if (cnt_q > CW'(T_PGM_MAX)) code_new = 3'd5;
               end
            end
         end
         S_RD: begin
            if (aen && chg) begin
               state_d  = S_ABORT;
               code_new = 3'd7;
            end else begin
               // Counter stops once aen drops, so this fires once.
               if (cnt_q == CW'(RD_LAT))
                  rdata_d = arr_q[{addr_q[7:3], 3'b000} +: 8];
               if (!aen) begin
                  state_d = S_IDLE;
                  op_end  = 1'b1;
                  if (cnt_q < CW'(RD_LAT)) code_new = 3'd6;
               end
            end
         end
         S_ABORT: begin
            if (!aen) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // A clear loses only to an error raised by a completing operation.
      new_err = code_new != 3'd0;
      if (err_clr_i && !(new_err && op_end)) begin
         err_d   = 1'b0;
         ecode_d = 3'd0;
      end else if (err_clr_i) begin
         err_d   = 1'b1;
         ecode_d = code_new;
      end else if (new_err) begin
         err_d = 1'b1;
         if (ecode_q == 3'd0) ecode_d = code_new;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         aen_d1_q <= 1'b0;
         cnt_q    <= '0;
         pgmen_q  <= 1'b0;
         rden_q   <= 1'b0;
         addr_q   <= '0;
         arr_q    <= ARR_RST;
         rdata_q  <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         ecode_q  <= '0;
      end else begin
         aen_d1_q <= aen;
         cnt_q    <= cnt_d;
         pgmen_q  <= pgmen_d;
         rden_q   <= rden_d;
         addr_q   <= addr_d;
         arr_q    <= arr_d;
         rdata_q  <= rdata_d;
         done_q   <= done_d;
         err_q    <= err_d;
         ecode_q  <= ecode_d;
      end
   end

   assign pin.efuse_rdata_o = rdata_q;
   assign pgm_done_o        = done_q;
   assign prot_err_o        = err_q;
   assign err_code_o        = ecode_q;

endmodule
